// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Holds the PC, issues one instruction-memory read per instruction, hands
// {instr, pc} to decode and picks the next PC from decode's next_pc_* outputs.
// Branches park the stage until exec resolves them; JALR parks it until the
// target register value arrives. This block performs no PC arithmetic.
//
// Handshakes:
//   imem : imem_req is a one-cycle pulse; imem_addr is held from that pulse
//          until imem_valid. imem_valid is only honoured in MEM.
//   decode: order=1 means instr/pc are valid; they stay stable until decode
//          raises done in a cycle where order=1, and the transfer happens at
//          that edge. done while order=0 has no effect.
module fetch_unit #(
    parameter int unsigned    W        = 32,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_valid,
    input  logic [W-1:0] imem_rdata,
    output logic         order,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc,
    input  logic         done,
    input  logic         next_pc_normal,
    input  logic         next_pc_wait_type,
    input  logic [W-1:0] next_pc,
    input  logic [W-1:0] next_pc_branched,
    input  logic         br_valid,
    input  logic         br_taken,
    input  logic         jr_valid,
    input  logic [W-1:0] jr_addr,
    output logic [31:0]  stall_cycles,
    output logic [2:0]   fsm_state
);

    typedef enum logic [2:0] {
        REQ     = 3'd0,
        MEM     = 3'd1,
        DEC     = 3'd2,
        WAIT_BR = 3'd3,
        WAIT_JR = 3'd4
    } state_t;

    state_t       state;
    logic [W-1:0] pc_q;
    logic [W-1:0] fallthru_q;
    logic [W-1:0] taken_q;

    // The JALR target is always halfword-aligned by clearing bit 0, so that
    // bit of jr_addr is deliberately never looked at.
    logic         jr_addr_lsb_unused;
    assign jr_addr_lsb_unused = jr_addr[0];

    // State is exported unchanged for observation.
    assign fsm_state = state;

    // Fetch sequencer: all outputs and held PCs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= REQ;
            pc_q         <= RESET_PC;
            fallthru_q   <= '0;
            taken_q      <= '0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            order        <= 1'b0;
            instr        <= '0;
            pc           <= RESET_PC;
            stall_cycles <= '0;
        end else begin
            // Every cycle parked on an unresolved target counts as a stall.
            if (state == WAIT_BR || state == WAIT_JR) begin
                stall_cycles <= stall_cycles + 32'd1;
            end

            case (state)
                REQ: begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc_q;
                    state     <= MEM;
                end

                MEM: begin
                    imem_req <= 1'b0;
                    if (imem_valid) begin
                        instr <= imem_rdata;
                        pc    <= pc_q;
                        order <= 1'b1;
                        state <= DEC;
                    end
                end

                DEC: begin
                    if (done && order) begin
                        order <= 1'b0;
                        if (next_pc_normal) begin
                            pc_q  <= next_pc;
                            state <= REQ;
                        end else if (next_pc_wait_type) begin
                            fallthru_q <= next_pc;
                            taken_q    <= next_pc_branched;
                            state      <= WAIT_BR;
                        end else begin
                            state <= WAIT_JR;
                        end
                    end
                end

                WAIT_BR: begin
                    if (br_valid) begin
                        pc_q  <= br_taken ? taken_q : fallthru_q;
                        state <= REQ;
                    end
                end

                WAIT_JR: begin
                    if (jr_valid) begin
                        pc_q  <= {jr_addr[W-1:1], 1'b0};
                        state <= REQ;
                    end
                end

                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable
// instruction memory, a decode driver and an expected-fetch-address queue.
module tb_fetch_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_valid = 1'b0;
    logic [W-1:0] imem_rdata = '0;
    logic         order;
    logic [W-1:0] instr;
    logic [W-1:0] pc;
    logic         done = 1'b0;
    logic         next_pc_normal = 1'b0;
    logic         next_pc_wait_type = 1'b0;
    logic [W-1:0] next_pc = '0;
    logic [W-1:0] next_pc_branched = '0;
    logic         br_valid = 1'b0;
    logic         br_taken = 1'b0;
    logic         jr_valid = 1'b0;
    logic [W-1:0] jr_addr = '0;
    logic [31:0]  stall_cycles;
    logic [2:0]   fsm_state;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           req_count = 0;
    int           mem_lat = 1;
    int           mem_cnt = 0;
    logic [W-1:0] mem_addr = '0;

    fetch_unit #(.W(W), .RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_valid        (imem_valid),
        .imem_rdata        (imem_rdata),
        .order             (order),
        .instr             (instr),
        .pc                (pc),
        .done              (done),
        .next_pc_normal    (next_pc_normal),
        .next_pc_wait_type (next_pc_wait_type),
        .next_pc           (next_pc),
        .next_pc_branched  (next_pc_branched),
        .br_valid          (br_valid),
        .br_taken          (br_taken),
        .jr_valid          (jr_valid),
        .jr_addr           (jr_addr),
        .stall_cycles      (stall_cycles),
        .fsm_state         (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- instruction memory model ----------------
    // Responds mem_lat cycles after the request pulse; keeps counting across
    // a DUT reset so an in-flight read can land after reset.
    always begin
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = instr_of(mem_addr);
            end
        end
        if (imem_req && !rst) begin
            mem_addr = imem_addr;
            mem_cnt  = mem_lat;
        end
    end

    // ---------------- scoreboard: fetch addresses ----------------
    always @(negedge clk) begin
        if (!rst && imem_req) begin
            req_count++;
            check_eq("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check_eq("imem_addr", imem_addr, exp_q.pop_front());
            end
        end
    end

    // ---------------- decode driver ----------------
    task automatic decode_step(input logic [W-1:0] exp_pc, input int hold,
                               input logic normal, input logic wtype,
                               input logic [W-1:0] npc, input logic [W-1:0] nbr,
                               input bit measure_gap);
        int n;
        int req_before;
        n = 0;
        while (!order && n < 50) begin
            step();
            n++;
        end
        check_eq("order_rise", 32'(order), 32'd1);
        check_eq("dec_pc", pc, exp_pc);
        check_eq("dec_instr", instr, instr_of(exp_pc));
        req_before = req_count;
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold_order", 32'(order), 32'd1);
            check_eq("hold_pc", pc, exp_pc);
            check_eq("hold_instr", instr, instr_of(exp_pc));
        end
        if (hold > 0) check_eq("hold_no_req", 32'(req_count), 32'(req_before));
        done              = 1'b1;
        next_pc_normal    = normal;
        next_pc_wait_type = wtype;
        next_pc           = npc;
        next_pc_branched  = nbr;
        step();
        done              = 1'b0;
        next_pc_normal    = 1'b0;
        next_pc_wait_type = 1'b0;
        next_pc           = '0;
        next_pc_branched  = '0;
        check_eq("order_fall", 32'(order), 32'd0);
        if (measure_gap) begin
            n = 1;
            while (!imem_req && n < 20) begin
                step();
                n++;
            end
            check_eq("done_req_gap", 32'(n), 32'd2);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        step();
        step();
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_imem_addr", imem_addr, 32'h0);
        check_eq("rst_order", 32'(order), 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_stall", stall_cycles, 32'h0);
        check_eq("rst_state", 32'(fsm_state), 32'd0);

        // 1: sequential fetch 0,4,8 with 2-cycle done->req gap
        exp_q.push_back(32'h0);
        rst = 1'b0;
        exp_q.push_back(32'h4);
        decode_step(32'h0, 0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
        exp_q.push_back(32'h8);
        decode_step(32'h4, 0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1);

        // 2: decode holds done low for 5 cycles
        exp_q.push_back(32'hC);
        decode_step(32'h8, 5, 1'b1, 1'b0, 32'hC, 32'h0, 1'b1);

        // 3a: branch taken, resolved in the 3rd wait cycle
        decode_step(32'hC, 0, 1'b0, 1'b1, 32'h14, 32'h40, 1'b0);
        check_eq("wait_br_state", 32'(fsm_state), 32'd3);
        step();
        step();
        br_valid = 1'b1;
        br_taken = 1'b1;
        exp_q.push_back(32'h40);
        step();
        br_valid = 1'b0;
        br_taken = 1'b0;
        check_eq("br_taken_stall", stall_cycles, 32'd3);
        check_eq("br_resolved_state", 32'(fsm_state), 32'd0);

        // 3b: branch not taken, resolved in the 1st wait cycle
        decode_step(32'h40, 0, 1'b0, 1'b1, 32'h14, 32'h40, 1'b0);
        br_valid = 1'b1;
        br_taken = 1'b0;
        exp_q.push_back(32'h14);
        step();
        br_valid = 1'b0;
        check_eq("br_not_taken_stall", stall_cycles, 32'd4);

        // 4: JALR with a spurious br_valid while waiting
        decode_step(32'h14, 0, 1'b0, 1'b0, 32'h18, 32'h99, 1'b0);
        check_eq("wait_jr_state", 32'(fsm_state), 32'd4);
        br_valid = 1'b1;
        br_taken = 1'b1;
        step();
        br_valid = 1'b0;
        br_taken = 1'b0;
        check_eq("jr_ignores_br", 32'(fsm_state), 32'd4);
        jr_valid = 1'b1;
        jr_addr  = 32'h101;
        exp_q.push_back(32'h100);
        step();
        jr_valid = 1'b0;
        jr_addr  = '0;
        check_eq("jr_stall", stall_cycles, 32'd6);
        check_eq("jr_resolved_state", 32'(fsm_state), 32'd0);

        // 5: reset during a 4-cycle read; stale data lands in REQ
        mem_lat = 4;
        exp_q.push_back(32'h104);
        decode_step(32'h100, 0, 1'b1, 1'b0, 32'h104, 32'h0, 1'b1);
        check_eq("slow_req_addr", imem_addr, 32'h104);
        step();
        check_eq("slow_mem_state", 32'(fsm_state), 32'd1);
        step();
        rst = 1'b1;
        #1;
        check_eq("async_rst_state", 32'(fsm_state), 32'd0);
        check_eq("async_rst_addr", imem_addr, 32'h0);
        check_eq("async_rst_stall", stall_cycles, 32'h0);
        step();
        check_eq("mid_rst_order", 32'(order), 32'd0);
        check_eq("mid_rst_pc", pc, 32'h0);
        exp_q.push_back(32'h0);
        step();
        rst = 1'b0;
        n = 0;
        while (!order && n < 30) begin
            step();
            n++;
        end
        check_eq("post_rst_latency", 32'(n), 32'd6);
        mem_lat = 1;

        // 6: stall counter wraps
        decode_step(32'h0, 0, 1'b0, 1'b1, 32'h4, 32'h80, 1'b0);
        force dut.stall_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles;
        br_valid = 1'b1;
        br_taken = 1'b1;
        exp_q.push_back(32'h80);
        step();
        br_valid = 1'b0;
        br_taken = 1'b0;
        check_eq("stall_wrap", stall_cycles, 32'h0);

        n = 0;
        while (!order && n < 20) begin
            step();
            n++;
        end
        check_eq("final_order", 32'(order), 32'd1);
        check_eq("final_pc", pc, 32'h80);
        check_eq("final_instr", instr, instr_of(32'h80));
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
